// File: rtl/axi_lite_fpmul_slave.sv
// AXI4-Lite slave wrapping a simplified binary32 multiplier behind four
// registers: OPA, OPB, CTRL (start/busy/done/ien) and a read-only RESULT.
//
// Handshake semantics: a transfer happens on every edge where valid and ready
// are both high. Writes are accepted only when AW and W are presented
// together. The slave then answers with a single-cycle awready/wready pulse,
// followed by bvalid, which is held until bready. Reads answer with a
// single-cycle arready pulse, followed by rvalid/rdata, which are held stable
// until rready. Register side effects take place on the edge that raises the
// ready pulse.
module axi_lite_fpmul_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int MUL_LATENCY        = 3
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            irq,
    output logic [1:0]                      dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [31:0] opa_q, opb_q, pa_q, pb_q, result_q;
    logic        ien_q;
    logic [1:0]  rd_sel_q;
    logic        wr_en, ar_en, ctrl_wr, start_req, clr_req, mul_last;
    logic [31:0] mul_res, rd_mux;
    logic        unused_ok;

    // Truncating binary32 multiply; zero/denormal inputs take priority over
    // infinities, and NaNs are never produced.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sign;
        logic [7:0]        ea, eb;
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [22:0]       m;
        sign = a[31] ^ b[31];
        ea   = a[30:23];
        eb   = b[30:23];
        p    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'sd1;
        end else begin
            m = p[45:23];
        end
        if (ea == 8'h00 || eb == 8'h00)      fp_mul = {sign, 31'b0};
        else if (ea == 8'hFF || eb == 8'hFF) fp_mul = {sign, 8'hFF, 23'b0};
        else if (e >= 10'sd255)              fp_mul = {sign, 8'hFF, 23'b0};
        else if (e <= 10'sd0)                fp_mul = {sign, 31'b0};
        else                                 fp_mul = {sign, e[7:0], m};
    endfunction

    assign wr_en     = s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_awready & ~s00_axi_bvalid;
    assign ar_en     = s00_axi_arvalid & ~s00_axi_arready & ~s00_axi_rvalid;
    assign ctrl_wr   = wr_en && (s00_axi_awaddr[3:2] == 2'd2) && s00_axi_wstrb[0];
    assign start_req = ctrl_wr && s00_axi_wdata[0];
    assign clr_req   = ctrl_wr && s00_axi_wdata[2];
    assign mul_last  = (state_q == ST_MUL) && (cnt_q == 3'(MUL_LATENCY - 1));
    assign mul_res   = fp_mul(pa_q, pb_q);

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;
    assign irq           = (state_q == ST_DONE) & ien_q;
    assign dbg_state     = state_q;
    assign unused_ok     = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Next-state logic: completion beats a coincident W1C; start beats W1C in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_req) state_d = ST_MUL;
            ST_MUL:  if (mul_last)  state_d = ST_DONE;
            ST_DONE: begin
                if (start_req)    state_d = ST_MUL;
                else if (clr_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, latency counter, operand snapshot and result capture.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            pa_q     <= 32'd0;
            pb_q     <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ST_MUL) ? cnt_q + 3'd1 : 3'd0;
            if (start_req && state_q != ST_MUL) begin
                pa_q <= opa_q;
                pb_q <= opb_q;
            end
            if (mul_last) result_q <= mul_res;
        end
    end

    // Software-visible registers, updated per byte strobe on write acceptance.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            opa_q <= 32'd0;
            opb_q <= 32'd0;
            ien_q <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (s00_axi_wstrb[i] && s00_axi_awaddr[3:2] == 2'd0) opa_q[8*i +: 8] <= s00_axi_wdata[8*i +: 8];
                if (s00_axi_wstrb[i] && s00_axi_awaddr[3:2] == 2'd1) opb_q[8*i +: 8] <= s00_axi_wdata[8*i +: 8];
            end
            if (ctrl_wr) ien_q <= s00_axi_wdata[3];
        end
    end

    // Write channel: ready pulse on acceptance, response held until bready.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
        end else begin
            s00_axi_awready <= wr_en;
            s00_axi_wready  <= wr_en;
            if (s00_axi_awready)                      s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
        end
    end

    // Read data mux; CTRL reflects live status at the latch cycle.
    always_comb begin
        rd_mux = 32'd0;
        case (rd_sel_q)
            2'd0: rd_mux = opa_q;
            2'd1: rd_mux = opb_q;
            2'd2: rd_mux = {28'd0, ien_q, state_q == ST_DONE, state_q == ST_MUL, 1'b0};
            2'd3: rd_mux = result_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // Read channel: address captured with arready, data latched the cycle after.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= 32'd0;
            rd_sel_q        <= 2'd0;
        end else begin
            s00_axi_arready <= ar_en;
            if (ar_en) rd_sel_q <= s00_axi_araddr[3:2];
            if (s00_axi_arready) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_fpmul_slave.sv
// Self-checking bench for axi_lite_fpmul_slave: register access, multiply
// vectors through a result scoreboard, control bits, handshake stalls, reset.
module tb_axi_lite_fpmul_slave;

    localparam int L = 3;
    localparam logic [3:0] A_OPA = 4'h0, A_OPB = 4'h4, A_CTRL = 4'h8, A_RES = 4'hC;

    logic        tb_ACLK = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp, dbg_state;
    logic        irq;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          done_rises = 0;
    int          base_rises;
    logic [1:0]  prev_state = 2'd0;
    logic [31:0] rd_tmp;

    logic [31:0] tv_a [13] = '{32'h3FC00000, 32'hC0000000, 32'h00000000, 32'h7F000000, 32'h00800000,
                               32'h7F800000, 32'h00000000, 32'h3FFFFFFF, 32'h3F800001, 32'hBF800000,
                               32'hC2F00000, 32'h7F000000, 32'h00800000};
    logic [31:0] tv_b [13] = '{32'h3FC00000, 32'h40400000, 32'h7F000000, 32'h7F000000, 32'h00800000,
                               32'h3F800000, 32'hFF800000, 32'h3FFFFFFF, 32'h3F800001, 32'hBF800000,
                               32'h3E800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] tv_e [13] = '{32'h40100000, 32'hC0C00000, 32'h00000000, 32'h7F800000, 32'h00000000,
                               32'h7F800000, 32'h80000000, 32'h407FFFFE, 32'h3F800002, 32'h3F800000,
                               32'hC1F00000, 32'h7F000000, 32'h00800000};

    axi_lite_fpmul_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .MUL_LATENCY(L)) dut (
        .s00_axi_aclk(tb_ACLK),     .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr),    .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),  .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),      .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),    .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),      .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),    .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),    .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),  .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),      .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),    .irq(irq),
        .dbg_state(dbg_state)
    );

    // Clock and cycle/completion bookkeeping.
    always #5 tb_ACLK = ~tb_ACLK;

    always @(posedge tb_ACLK) begin
        cyc        <= cyc + 1;
        prev_state <= dbg_state;
        if (dbg_state == 2'd2 && prev_state != 2'd2) done_rises <= done_rises + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    // Completes a write whose AW/W signals are already driven.
    task automatic finish_write();
        int n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        check("aw_accept", {31'b0, awready}, 32'd1);
        if (!awready) begin awvalid = 0; wvalid = 0; return; end
        last_wr_cyc = cyc;
        tick();
        awvalid = 0;
        wvalid  = 0;
        bready  = 1;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        check("bvalid", {31'b0, bvalid}, 32'd1);
        check("bresp", {30'b0, bresp}, 32'd0);
        tick();
        bready = 0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1;
        wvalid  = 1;
        finish_write();
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n = 0;
        araddr  = addr;
        arvalid = 1;
        while (!arready && n < 50) begin tick(); n++; end
        check("ar_accept", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        check("rvalid", {31'b0, rvalid}, 32'd1);
        check("rresp", {30'b0, rresp}, 32'd0);
        data   = rdata;
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic read_check(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic wait_done();
        logic [31:0] d;
        int n = 0;
        axi_read(A_CTRL, d);
        while (!d[2] && n < 20) begin axi_read(A_CTRL, d); n++; end
        check("done_set", {31'b0, d[2]}, 32'd1);
    endtask

    // Scoreboard pop: compares a RESULT read against the oldest expectation.
    task automatic check_result(input string tag);
        logic [31:0] d;
        axi_read(A_RES, d);
        if (exp_q.size() == 0) check({tag, "_noexp"}, d, 32'hxxxxxxxx);
        else check(tag, d, exp_q.pop_front());
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input string tag);
        axi_write(A_OPA, a, 4'hF);
        axi_write(A_OPB, b, 4'hF);
        exp_q.push_back(e);
        axi_write(A_CTRL, 32'h1, 4'hF);
        wait_done();
        check_result(tag);
        axi_write(A_CTRL, 32'h4, 4'hF);
    endtask

    initial begin
        aresetn = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = 0; wstrb = 0;
        repeat (3) tick();
        aresetn = 1;

        // Reset state
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready", {31'b0, wready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        read_check(A_OPA, 32'd0, "rst_opa");
        read_check(A_OPB, 32'd0, "rst_opb");
        read_check(A_CTRL, 32'd0, "rst_ctrl");
        read_check(A_RES, 32'd0, "rst_result");

        // 2.0 * 3.0 with a concurrent CTRL read and exact latency check
        axi_write(A_OPA, 32'h40000000, 4'hF);
        axi_write(A_OPB, 32'h40400000, 4'hF);
        exp_q.push_back(32'h40C00000);
        fork
            axi_write(A_CTRL, 32'h1, 4'hF);
            begin axi_read(A_CTRL, rd_tmp); check("busy_read", rd_tmp, 32'h2); end
        join
        for (int n = 0; n < 20 && cyc < last_wr_cyc + L - 1; n++) tick();
        check("lat_still_mul", {30'b0, dbg_state}, 32'd1);
        tick();
        check("lat_done", {30'b0, dbg_state}, 32'd2);
        check("irq_ien0", {31'b0, irq}, 32'd0);
        read_check(A_CTRL, 32'h4, "ctrl_done");
        check_result("mul_2x3");
        axi_write(A_CTRL, 32'h4, 4'hF);
        read_check(A_CTRL, 32'h0, "ctrl_cleared");

        // Arithmetic vectors
        for (int i = 0; i < 13; i++) run_mul(tv_a[i], tv_b[i], tv_e[i], $sformatf("mul_vec%0d", i));

        // Interrupt enable and W1C of done keeping ien
        axi_write(A_CTRL, 32'h8, 4'hF);
        axi_write(A_OPA, 32'h3F800000, 4'hF);
        axi_write(A_OPB, 32'h40000000, 4'hF);
        exp_q.push_back(32'h40000000);
        axi_write(A_CTRL, 32'h9, 4'hF);
        wait_done();
        check("irq_set", {31'b0, irq}, 32'd1);
        check_result("mul_irq");
        axi_write(A_CTRL, 32'hC, 4'hF);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        read_check(A_CTRL, 32'h8, "ctrl_ien_kept");
        axi_write(A_CTRL, 32'h0, 4'hF);

        // W1C landing on the completion edge leaves done set
        axi_write(A_OPA, 32'h40000000, 4'hF);
        axi_write(A_OPB, 32'h40400000, 4'hF);
        exp_q.push_back(32'h40C00000);
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_write(A_CTRL, 32'h4, 4'hF);
        check("w1c_vs_done_state", {30'b0, dbg_state}, 32'd2);
        read_check(A_CTRL, 32'h4, "w1c_vs_done_ctrl");
        check_result("mul_w1c_race");

        // Start+clear in DONE restarts; a start while busy is ignored
        axi_write(A_OPA, 32'h3FC00000, 4'hF);
        axi_write(A_OPB, 32'h3FC00000, 4'hF);
        exp_q.push_back(32'h40100000);
        base_rises = done_rises;
        axi_write(A_CTRL, 32'h5, 4'hF);
        check("start_wins_state", {30'b0, dbg_state}, 32'd1);
        axi_write(A_CTRL, 32'h1, 4'hF);
        check("busy_start_ignored", {30'b0, dbg_state}, 32'd2);
        repeat (8) tick();
        check("done_once", 32'(done_rises - base_rises), 32'd1);
        check_result("mul_busy_start");
        axi_write(A_CTRL, 32'h4, 4'hF);

        // Byte strobes
        axi_write(A_OPA, 32'h0, 4'hF);
        axi_write(A_OPA, 32'hFFFFFFFF, 4'b0011);
        read_check(A_OPA, 32'h0000FFFF, "wstrb_low_half");

        // awvalid leading wvalid by three cycles
        awaddr = A_OPB; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("aw_lone_awready", {31'b0, awready}, 32'd0);
            check("aw_lone_wready", {31'b0, wready}, 32'd0);
        end
        wvalid = 1;
        finish_write();
        read_check(A_OPB, 32'h12345678, "aw_lead_data");

        // bready held low: response held, next write blocked
        awaddr = A_OPB; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        for (int n = 0; n < 50 && !awready; n++) tick();
        check("bhold_accept", {31'b0, awready}, 32'd1);
        tick();
        awaddr = A_OPA; wdata = 32'h5A5A5A5A;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bhold_bvalid", {31'b0, bvalid}, 32'd1);
            check("bhold_awready", {31'b0, awready}, 32'd0);
        end
        bready = 1;
        tick();
        bready = 0;
        finish_write();
        read_check(A_OPB, 32'hA5A5A5A5, "bhold_first");
        read_check(A_OPA, 32'h5A5A5A5A, "bhold_second");

        // rready held low while the register underneath changes
        araddr = A_OPA; arvalid = 1; rready = 0;
        for (int n = 0; n < 50 && !arready; n++) tick();
        check("rhold_accept", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 0;
        for (int n = 0; n < 50 && !rvalid; n++) tick();
        fork
            for (int i = 0; i < 6; i++) begin
                tick();
                check("rhold_data", rdata, 32'h5A5A5A5A);
                check("rhold_valid", {31'b0, rvalid}, 32'd1);
            end
            axi_write(A_OPA, 32'hCAFEF00D, 4'hF);
        join
        rready = 1;
        tick();
        rready = 0;
        read_check(A_OPA, 32'hCAFEF00D, "rhold_new_value");

        // Reset during MUL aborts everything
        axi_write(A_CTRL, 32'h8, 4'hF);
        axi_write(A_OPA, 32'h40000000, 4'hF);
        axi_write(A_OPB, 32'h40400000, 4'hF);
        axi_write(A_CTRL, 32'h9, 4'hF);
        aresetn = 0;
        tick();
        aresetn = 1;
        check("midrst_state", {30'b0, dbg_state}, 32'd0);
        check("midrst_irq", {31'b0, irq}, 32'd0);
        repeat (5) tick();
        check("midrst_irq_later", {31'b0, irq}, 32'd0);
        read_check(A_CTRL, 32'h0, "midrst_ctrl");
        read_check(A_RES, 32'h0, "midrst_result");
        read_check(A_OPA, 32'h0, "midrst_opa");
        run_mul(32'h3FC00000, 32'h40400000, 32'h40900000, "mul_after_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_fpmul_slave.md
Name: axi_lite_fpmul_slave

Overview:
- AXI4-Lite slave that exposes a single-precision floating-point multiplier as four 32-bit registers.
- It is the responder end of the S00_AXI interface that the master BFM and the MicroBlaze drive.
- Software writes operands, writes a start bit, then polls the busy/done bits or waits for an interrupt before reading the result.
- It sits behind the AXI interconnect at the S00_AXI base address.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses addr[3:2].
- MUL_LATENCY, 3, cycles from busy rising to result valid; legal range 1..7.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_aresetn  in  1  synchronous, active-low reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  write response, always 2'b00.
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  always 2'b00.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- irq  out  1  level interrupt, equal to done & CTRL.ien.

Behaviour:
- Reset (synchronous, aresetn=0 at a clock edge):
  - All ready/valid outputs are 0; bresp, rresp and rdata are 0; irq is 0.
  - OPA, OPB and RESULT are 0; CTRL is 0; the FSM goes to IDLE.
  - Reset overrides any transaction or computation in flight; no partial result survives.
- Register map (addr[3:2]):
  - 0: OPA, R/W.
  - 1: OPB, R/W.
  - 2: CTRL.
    - bit0 start: write-1 starts a computation; reads 0.
    - bit1 busy: read-only.
    - bit2 done: write-1-to-clear.
    - bit3 ien: R/W.
    - Other bits read 0.
  - 3: RESULT, read-only. Writes to it are accepted with OKAY and have no effect.
- Write channel:
  - awready and wready pulse together for one cycle when awvalid & wvalid & !awready & !bvalid.
  - Register update happens on that same edge, honouring wstrb per byte.
  - bvalid rises the next cycle and is held until bready.
  - No new write is accepted while bvalid=1.
  - A lone awvalid or a lone wvalid waits; it is never accepted alone.
- Read channel:
  - arready pulses for one cycle when arvalid & !arready & !rvalid.
  - rdata is latched on the next cycle and rvalid rises; both are held stable until rready.
  - Reads and writes may proceed concurrently.
  - A read of CTRL returns the status as of the latch cycle.
- Compute FSM (IDLE -> MUL -> DONE -> IDLE):
  - IDLE: a write with start=1 (wstrb[0]=1) at edge T latches OPA/OPB into pipeline inputs. busy=1 from T+1.
  - MUL: a counter runs MUL_LATENCY cycles. At edge T+MUL_LATENCY, RESULT is written, busy drops and done sets.
  - DONE: same as IDLE, except done=1 until cleared. A new start clears done and re-enters MUL.
  - start while busy is ignored and the write still gets OKAY.
  - OPA/OPB writes during MUL do not affect the running computation.
  - If a done W1C and the completion edge coincide, done ends at 1.
  - If a start and a done W1C arrive in the same write, start wins: done=0, busy=1.
- Arithmetic (IEEE-754 binary32, simplified):
  - sign = sa ^ sb.
  - If either exponent is 0 (zero/denormal flushed): result is {sign, 31'b0}. This check takes priority.
  - Else if either exponent is 255: result is {sign, 8'hFF, 23'b0} (no NaN generation).
  - Else:
    - e = ea + eb - 127, computed in 10-bit signed arithmetic.
    - p = {1,ma} * {1,mb}, a 48-bit product.
    - If p[47]=1: mantissa = p[46:24] and e is incremented by 1. Otherwise mantissa = p[45:23].
    - Rounding is truncation.
    - If e >= 255: result is signed infinity.
    - If e <= 0: result is signed zero.

Test Plan:
- Reset check: OPA=0x40000000 (2.0), OPB=0x40400000 (3.0), start -> busy read 1 immediately after; done=1 after 3 cycles; RESULT=0x40C00000 (6.0); every read and write returns bresp/rresp=00.
- Mantissa normalisation: OPA=OPB=0x3FC00000 (1.5) -> RESULT=0x40100000 (2.25). Sign: 0xC0000000 × 0x40400000 -> 0xC0C00000.
- Zero and overflow: 0x00000000 × 0x7F000000 -> 0x00000000. 0x7F000000 × 0x7F000000 -> 0x7F800000. 0x00800000 × 0x00800000 -> 0x00000000 (underflow).
- Control:
  - ien=1 with completion -> irq=1; writing CTRL=0x4|0x8 clears done and irq while ien stays 1.
  - start issued while busy is ignored: RESULT keeps the first product and done sets exactly once.
  - wstrb=4'b0011 write of 0xFFFFFFFF into OPA=0 reads back 0x0000FFFF.
- Handshake stress:
  - awvalid asserted 3 cycles before wvalid -> no acceptance until both are high.
  - bready held low 5 cycles -> bvalid is held and a second write is not accepted.
  - rready held low -> rdata stays stable.
- Reset mid-operation: aresetn=0 for one cycle during MUL -> busy=0, done=0, RESULT=0 and irq=0 afterward; the next start computes correctly.
